psum_collector: RTL and testbench

PSUM_COLLECTOR -- requirements
Module: PsumCollector

---
 rtl/psum_collector.sv | 215 +++++++++++++++++++++
 tb/tb_psum_collector.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_collector.sv
`default_nettype none
// ============================================================================
// Module      : psum_collector
// Description : Collects PEROW-lane partial-sum vectors over a rdy/ack
//               handshake into a small vector FIFO, then serializes them one
//               lane per cycle into global-buffer writes at consecutive
//               addresses starting at i_base_addr.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_start         : job start pulse (accepted only when idle)
//   i_total         : vectors in the job (0 behaves as 1)
//   i_base_addr     : first global-buffer write address
//   i_relu          : ReLU enable, captured at job start
//   POUT_rdy        : sender has a vector valid
//   POUT_ack        : collector accepts the vector this cycle
//   i_Psum_POUT     : psum vector, lane 0 in the least significant bits
//   i_gb_stall      : global buffer cannot accept a write this cycle
//   o_gb_wen        : global-buffer write strobe (registered)
//   o_gb_waddr      : global-buffer write address
//   o_gb_wdata      : global-buffer write data
//   o_busy          : job in progress
//   o_done          : one-cycle job completion pulse
// Build option
//   PSUMCOL_RELU_EN : when defined, negative lanes are written as zero if
//                     i_relu was set at job start
// ============================================================================
module psum_collector #(
    parameter int PEROW    = 4,
    parameter int PSUMDWD  = 16,
    parameter int FIFODEP  = 4,
    parameter int GBADDRWD = 12
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [15:0]                i_total,
    input  logic [GBADDRWD-1:0]        i_base_addr,
    input  logic                       i_relu,
    input  logic                       POUT_rdy,
    output logic                       POUT_ack,
    input  logic [PEROW*PSUMDWD-1:0]   i_Psum_POUT,
    input  logic                       i_gb_stall,
    output logic                       o_gb_wen,
    output logic [GBADDRWD-1:0]        o_gb_waddr,
    output logic [PSUMDWD-1:0]         o_gb_wdata,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int c_VEC_W  = PEROW * PSUMDWD;
    localparam int c_PTR_W  = (FIFODEP > 1) ? $clog2(FIFODEP) : 1;
    localparam int c_LANE_W = (PEROW > 1) ? $clog2(PEROW) : 1;
    localparam logic [c_PTR_W:0]    c_FULL_CNT  = (c_PTR_W + 1)'(FIFODEP);
    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(PEROW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Vector FIFO
    logic [c_VEC_W-1:0]  r_fifo [FIFODEP];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_count;

    // Job bookkeeping and serializer
    logic [15:0]         r_total;
    logic [15:0]         r_xfer_cnt;
    logic [GBADDRWD-1:0] r_next_addr;
    logic [c_LANE_W-1:0] r_lane;

    logic                w_start;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_emit;
    logic                w_pop;
    logic                w_last_xfer;
    logic [c_VEC_W-1:0]  w_head;
    logic [PSUMDWD-1:0]  w_lanes [PEROW];
    logic [PSUMDWD-1:0]  w_lane_raw;
    logic [PSUMDWD-1:0]  w_lane_out;

    assign w_start     = (r_state == S_IDLE) && i_start;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_FULL_CNT);
    assign POUT_ack    = (r_state == S_RUN) && !w_full;
    assign w_push      = POUT_rdy && POUT_ack;
    // A lane is emitted whenever a vector is buffered and the GB can take it;
    // the head vector is released once its last lane goes out.
    assign w_emit      = !w_empty && !i_gb_stall;
    assign w_pop       = w_emit && (r_lane == c_LAST_LANE);
    assign w_last_xfer = w_push && ((r_xfer_cnt + 16'd1) == r_total);

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);

    assign w_head      = r_fifo[r_rd_ptr];

    generate
        for (genvar g = 0; g < PEROW; g++) begin : g_lane_split
            assign w_lanes[g] = w_head[g*PSUMDWD +: PSUMDWD];
        end
    endgenerate

    assign w_lane_raw = w_lanes[r_lane];

`ifdef PSUMCOL_RELU_EN
    logic r_relu;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_relu <= 1'b0;
        end else if (w_start) begin
            r_relu <= i_relu;
        end
    end

    assign w_lane_out = (r_relu && w_lane_raw[PSUMDWD-1]) ? '0 : w_lane_raw;
`else
    logic w_unused_relu;
    assign w_unused_relu = i_relu;
    assign w_lane_out    = w_lane_raw;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start)     w_next_state = S_RUN;
            S_RUN:   if (w_last_xfer) w_next_state = S_DRAIN;
            // An empty FIFO in DRAIN means the final lane is on the GB port
            // this cycle, so completion is flagged the cycle after it.
            S_DRAIN: if (w_empty)     w_next_state = S_DONE;
            S_DONE:                   w_next_state = S_IDLE;
            default:                  w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO storage and control
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= i_Psum_POUT;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Job counters and lane serializer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_total     <= 16'd1;
            r_xfer_cnt  <= '0;
            r_next_addr <= '0;
            r_lane      <= '0;
            o_gb_wen    <= 1'b0;
            o_gb_waddr  <= '0;
            o_gb_wdata  <= '0;
        end else begin
            if (w_start) begin
                r_total     <= (i_total == '0) ? 16'd1 : i_total;
                r_xfer_cnt  <= '0;
                r_next_addr <= i_base_addr;
            end else if (w_push) begin
                r_xfer_cnt  <= r_xfer_cnt + 16'd1;
            end

            o_gb_wen <= w_emit;
            if (w_emit) begin
                o_gb_wdata  <= w_lane_out;
                o_gb_waddr  <= r_next_addr;
                r_next_addr <= r_next_addr + GBADDRWD'(1);
                r_lane      <= (r_lane == c_LAST_LANE) ? '0 : r_lane + c_LANE_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_collector
// Description : Self-checking bench for psum_collector: table of directed
//               jobs plus hand-written backpressure, mid-vector stall and
//               reset-during-drain sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_collector;

    localparam int PEROW    = 4;
    localparam int PSUMDWD  = 16;
    localparam int FIFODEP  = 4;
    localparam int GBADDRWD = 12;

    logic                     i_clk = 1'b0;
    logic                     i_rst_n;
    logic                     i_start;
    logic [15:0]              i_total;
    logic [GBADDRWD-1:0]      i_base_addr;
    logic                     i_relu;
    logic                     POUT_rdy;
    logic                     POUT_ack;
    logic [PEROW*PSUMDWD-1:0] i_Psum_POUT;
    logic                     i_gb_stall;
    logic                     o_gb_wen;
    logic [GBADDRWD-1:0]      o_gb_waddr;
    logic [PSUMDWD-1:0]       o_gb_wdata;
    logic                     o_busy;
    logic                     o_done;

    always #5 i_clk = ~i_clk;

    psum_collector #(
        .PEROW    (PEROW),
        .PSUMDWD  (PSUMDWD),
        .FIFODEP  (FIFODEP),
        .GBADDRWD (GBADDRWD)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_total     (i_total),
        .i_base_addr (i_base_addr),
        .i_relu      (i_relu),
        .POUT_rdy    (POUT_rdy),
        .POUT_ack    (POUT_ack),
        .i_Psum_POUT (i_Psum_POUT),
        .i_gb_stall  (i_gb_stall),
        .o_gb_wen    (o_gb_wen),
        .o_gb_waddr  (o_gb_waddr),
        .o_gb_wdata  (o_gb_wdata),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor (samples on the falling edge) ----------------
    logic [GBADDRWD-1:0] wr_addr [$];
    logic [PSUMDWD-1:0]  wr_data [$];
    int ncyc       = 0;
    int xfer_cnt   = 0;
    int done_cnt   = 0;
    int first_xfer = -1;
    int first_wr   = -1;

    always @(negedge i_clk) begin
        ncyc++;
        if (POUT_rdy && POUT_ack) begin
            if (first_xfer < 0) first_xfer = ncyc;
            xfer_cnt++;
        end
        if (o_gb_wen) begin
            if (first_wr < 0) first_wr = ncyc;
            wr_addr.push_back(o_gb_waddr);
            wr_data.push_back(o_gb_wdata);
        end
        if (o_done) done_cnt++;
    end

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        xfer_cnt   = 0;
        done_cnt   = 0;
        first_xfer = -1;
        first_wr   = -1;
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [63:0] p4(input int a, input int b, input int c, input int d);
        logic [63:0] r;
        r[15:0]  = a[15:0];
        r[31:16] = b[15:0];
        r[47:32] = c[15:0];
        r[63:48] = d[15:0];
        return r;
    endfunction

    logic [63:0] vec_buf [8];

    task automatic drive_job(input int total, input logic [11:0] base, input logic relu);
        int   nvec;
        int   idx;
        int   guard;
        logic a;
        nvec  = (total == 0) ? 1 : total;
        idx   = 0;
        guard = 0;
        @(posedge i_clk); #1;
        i_total     = 16'(total);
        i_base_addr = base;
        i_relu      = relu;
        i_start     = 1'b1;
        @(posedge i_clk); #1;
        i_start     = 1'b0;
        POUT_rdy    = 1'b1;
        i_Psum_POUT = vec_buf[0];
        while (idx < nvec && guard < 400) begin
            @(negedge i_clk);
            a = POUT_ack;
            @(posedge i_clk); #1;
            guard++;
            if (a) begin
                idx++;
                if (idx < nvec) i_Psum_POUT = vec_buf[idx];
            end
        end
        POUT_rdy = 1'b0;
        if (idx < nvec) check("drive_timeout", 32'(idx), 32'(nvec));
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (done_cnt == 0 && n < bound) begin
            @(posedge i_clk);
            n++;
        end
        repeat (3) @(posedge i_clk);
        #1;
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("idle_after_done", 32'(o_busy), 32'd0);
    endtask

    // ---------------- directed job table ----------------
    typedef struct {
        int          total;
        logic [11:0] base;
        logic        relu;
        logic [63:0] v0;
        logic [63:0] v1;
        logic [127:0] exp;
        int          nw;
    } job_t;

    job_t jobs [5];

    task automatic run_table_job(input int j);
        logic [11:0] ea;
        clear_mon();
        vec_buf[0] = jobs[j].v0;
        vec_buf[1] = jobs[j].v1;
        i_gb_stall = 1'b0;
        drive_job(jobs[j].total, jobs[j].base, jobs[j].relu);
        wait_done(100);
        check($sformatf("job%0d_nwrites", j), 32'(wr_addr.size()), 32'(jobs[j].nw));
        for (int k = 0; k < jobs[j].nw && k < wr_addr.size(); k++) begin
            ea = jobs[j].base + 12'(k);
            check($sformatf("job%0d_addr%0d", j, k), 32'(wr_addr[k]), 32'(ea));
            check($sformatf("job%0d_data%0d", j, k), 32'(wr_data[k]), 32'(jobs[j].exp[k*16 +: 16]));
        end
        check($sformatf("job%0d_latency", j), 32'(first_wr - first_xfer), 32'd2);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        i_rst_n     = 1'b0;
        i_start     = 1'b0;
        i_total     = '0;
        i_base_addr = '0;
        i_relu      = 1'b0;
        POUT_rdy    = 1'b0;
        i_Psum_POUT = '0;
        i_gb_stall  = 1'b0;

        jobs[0] = '{2, 12'h010, 1'b0, p4(1, 2, 3, 4), p4(5, 6, 7, 8),
                    {p4(5, 6, 7, 8), p4(1, 2, 3, 4)}, 8};
        jobs[1] = '{1, 12'hFFE, 1'b0, p4(100, -200, 300, -400), 64'h0,
                    {64'h0, p4(100, -200, 300, -400)}, 4};
`ifdef PSUMCOL_RELU_EN
        jobs[2] = '{1, 12'h020, 1'b1, p4(-5, 3, -1, 0), 64'h0,
                    {64'h0, p4(0, 3, 0, 0)}, 4};
`else
        jobs[2] = '{1, 12'h020, 1'b1, p4(-5, 3, -1, 0), 64'h0,
                    {64'h0, p4(-5, 3, -1, 0)}, 4};
`endif
        jobs[3] = '{1, 12'h030, 1'b0, p4(-32768, 32767, -1, 1), 64'h0,
                    {64'h0, p4(-32768, 32767, -1, 1)}, 4};
        jobs[4] = '{0, 12'h500, 1'b0, p4(7, -8, 9, -10), 64'h0,
                    {64'h0, p4(7, -8, 9, -10)}, 4};

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ack",   32'(POUT_ack),   32'd0);
        check("rst_wen",   32'(o_gb_wen),   32'd0);
        check("rst_waddr", 32'(o_gb_waddr), 32'd0);
        check("rst_wdata", 32'(o_gb_wdata), 32'd0);
        check("rst_busy",  32'(o_busy),     32'd0);
        check("rst_done",  32'(o_done),     32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        for (int j = 0; j < 5; j++) begin
            run_table_job(j);
        end

        // Backpressure: GB stalled, FIFO fills after 4 vectors; a stray start
        // during the job must not disturb the addressing.
        clear_mon();
        for (int k = 0; k < 8; k++) begin
            vec_buf[k] = p4(k*4 + 1, k*4 + 2, k*4 + 3, k*4 + 4);
        end
        i_gb_stall = 1'b1;
        fork
            drive_job(8, 12'h100, 1'b0);
            begin
                repeat (12) @(posedge i_clk);
                #1;
                check("bp_xfers",    32'(xfer_cnt),       32'd4);
                check("bp_ack_low",  32'(POUT_ack),       32'd0);
                check("bp_nowrites", 32'(wr_addr.size()), 32'd0);
                check("bp_busy",     32'(o_busy),         32'd1);
                i_base_addr = 12'h300;
                i_start     = 1'b1;
                @(posedge i_clk); #1;
                i_start     = 1'b0;
                i_gb_stall  = 1'b0;
            end
        join
        wait_done(300);
        check("bp_nwrites", 32'(wr_addr.size()), 32'd32);
        for (int k = 0; k < 32 && k < wr_addr.size(); k++) begin
            check($sformatf("bp_addr%0d", k), 32'(wr_addr[k]), 32'(12'h100 + k));
            check($sformatf("bp_data%0d", k), 32'(wr_data[k]), 32'(k + 1));
        end

        // Stall for 3 cycles while lane 2 of the first vector is selected
        clear_mon();
        vec_buf[0] = p4(10, 11, 12, 13);
        vec_buf[1] = p4(14, 15, 16, 17);
        i_gb_stall = 1'b0;
        fork
            drive_job(2, 12'h040, 1'b0);
            begin
                g = 0;
                while (wr_addr.size() < 1 && g < 100) begin
                    @(posedge i_clk);
                    g++;
                end
                #1;
                i_gb_stall = 1'b1;
                repeat (3) @(posedge i_clk);
                #1;
                check("sm_held_writes", 32'(wr_addr.size()), 32'd2);
                check("sm_wen_low",     32'(o_gb_wen),       32'd0);
                i_gb_stall = 1'b0;
            end
        join
        wait_done(100);
        check("sm_nwrites", 32'(wr_addr.size()), 32'd8);
        for (int k = 0; k < 8 && k < wr_addr.size(); k++) begin
            check($sformatf("sm_addr%0d", k), 32'(wr_addr[k]), 32'(12'h040 + k));
            check($sformatf("sm_data%0d", k), 32'(wr_data[k]), 32'(10 + k));
        end

        // Reset while in DRAIN with two vectors buffered
        clear_mon();
        vec_buf[0] = p4(21, 22, 23, 24);
        vec_buf[1] = p4(25, 26, 27, 28);
        i_gb_stall = 1'b1;
        drive_job(2, 12'h080, 1'b0);
        check("rd_busy_drain", 32'(o_busy),   32'd1);
        check("rd_ack_drain",  32'(POUT_ack), 32'd0);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check("rd_wen",   32'(o_gb_wen),   32'd0);
        check("rd_busy",  32'(o_busy),     32'd0);
        check("rd_ack",   32'(POUT_ack),   32'd0);
        check("rd_done",  32'(o_done),     32'd0);
        check("rd_waddr", 32'(o_gb_waddr), 32'd0);
        @(posedge i_clk); #1;
        i_rst_n    = 1'b1;
        i_gb_stall = 1'b0;
        repeat (20) @(posedge i_clk);
        #1;
        check("rd_no_writes", 32'(wr_addr.size()), 32'd0);
        check("rd_no_done",   32'(done_cnt),       32'd0);
        check("rd_idle",      32'(o_busy),         32'd0);

        // Normal operation after the mid-job reset
        run_table_job(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
